x_w_result_sender: RTL and testbench

- Execute-side transmitter for the X__W interface.
- Sits at the tail of each execute pipe. Accepts finished results from the pipe datapath over a val/rdy port and buffers them in order.
- Presents the oldest result to the writeback/commit unit.
- The writeback side grants one pipe per cycle by round-robin arbitration and drives rdy only on grant. This block holds each result stable until granted, so the pipe never stalls on arbitration loss unless the buffer is full.

---
 rtl/x_w_pkg.sv | 44 ++++
 rtl/x_w_intf.sv | 30 +++
 rtl/x_w_entry_queue.sv | 77 +++++++
 rtl/x_w_result_sender.sv | 92 +++++++++
 tb/tb_x_w_result_sender.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/x_w_pkg.sv
`default_nettype none
// ============================================================================
// Module      : x_w_pkg
// Description : Shared types and constants for the X->W result transmitter.
//               x_w_entry_t is the unit of storage and transfer:
//               {pc, seq_num, waddr, wdata, wen}.
// Revision    : 1.0 - initial release
// ============================================================================
package x_w_pkg;

    // Sequence-number width baked into x_w_entry_t. Must match the
    // p_seq_num_bits of the X__WIntf instance and of x_w_result_sender.
    localparam int X_W_SEQ_NUM_BITS = 5;

    // Total packed width of one result entry.
    localparam int X_W_DATA_BITS = 32 + X_W_SEQ_NUM_BITS + 5 + 32 + 1;

    typedef struct packed {
        logic [31:0]                 pc;
        logic [X_W_SEQ_NUM_BITS-1:0] seq_num;
        logic [4:0]                  waddr;
        logic [31:0]                 wdata;
        logic                        wen;
    } x_w_entry_t;

    // Assemble an entry from its individual fields.
    function automatic x_w_entry_t x_w_make_entry(
        input logic [31:0]                 pc,
        input logic [X_W_SEQ_NUM_BITS-1:0] seq_num,
        input logic [4:0]                  waddr,
        input logic [31:0]                 wdata,
        input logic                        wen
    );
        x_w_entry_t e;
        e.pc      = pc;
        e.seq_num = seq_num;
        e.waddr   = waddr;
        e.wdata   = wdata;
        e.wen     = wen;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/x_w_intf.sv
`default_nettype none
// ============================================================================
// Module      : X__WIntf
// Description : Execute-to-writeback result interface. The execute side
//               (X_intf) drives the result and val; the writeback side
//               (W_intf) drives rdy, only while it grants this pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface X__WIntf #(
    parameter int p_seq_num_bits = 5
);
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [4:0]                waddr;
    logic [31:0]               wdata;
    logic                      wen;
    logic                      val;
    logic                      rdy;

    modport X_intf (
        output pc, seq_num, waddr, wdata, wen, val,
        input  rdy
    );

    modport W_intf (
        input  pc, seq_num, waddr, wdata, wen, val,
        output rdy
    );
endinterface
`default_nettype wire

// File: rtl/x_w_entry_queue.sv
`default_nettype none
// ============================================================================
// Module      : x_w_entry_queue
// Description : In-order val/rdy FIFO of x_w_entry_t. Pointers carry one
//               extra wrap bit so full and empty are distinguishable with
//               equal indices. enq_rdy_o is a register (== !full) so nothing
//               on the dequeue side reaches it combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module x_w_entry_queue
    import x_w_pkg::*;
#(
    parameter int p_depth = 2
)(
    input  logic       clk,
    input  logic       rst,          // synchronous, active-low

    input  logic       enq_val_i,
    output logic       enq_rdy_o,
    input  x_w_entry_t enq_entry_i,

    output logic       deq_val_o,
    input  logic       deq_rdy_i,
    output x_w_entry_t deq_entry_o
);

    localparam int             PTR_W   = $clog2(p_depth);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           rdy_q;
    x_w_entry_t     mem_q [p_depth];

    logic empty;
    logic full_d;
    logic enq_fire;
    logic deq_fire;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign enq_fire = enq_val_i & rdy_q;
    assign deq_fire = ~empty & deq_rdy_i;

    assign enq_rdy_o   = rdy_q;
    assign deq_val_o   = ~empty;
    assign deq_entry_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Next pointers and next-cycle fullness (feeds the registered ready).
    always_comb begin
        wr_ptr_d = enq_fire ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = deq_fire ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        full_d   = (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]) &&
                   (wr_ptr_d[PTR_W]     != rd_ptr_d[PTR_W]);
    end

    // Pointer and ready state; reset drops every buffered entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= ~full_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= enq_entry_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/x_w_result_sender.sv
`default_nettype none
// ============================================================================
// Module      : x_w_result_sender
// Description : Execute-side transmitter for the X__W interface. Buffers
//               finished results in order and holds the oldest one on W
//               until the writeback arbiter grants it (W.rdy).
//               Build option X_W_RESULT_SENDER_BYPASS_EN: when the buffer is
//               empty an incoming result is presented on W in the same cycle
//               and is only written to the buffer if not taken at once.
// Revision    : 1.0 - initial release
// ============================================================================
module x_w_result_sender
    import x_w_pkg::*;
#(
    parameter int p_depth        = 2,
    parameter int p_seq_num_bits = X_W_SEQ_NUM_BITS
)(
    input  logic                      clk,
    input  logic                      rst,        // synchronous, active-low

    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic [31:0]               in_pc,
    input  logic [p_seq_num_bits-1:0] in_seq_num,
    input  logic [4:0]                in_waddr,
    input  logic [31:0]               in_wdata,
    input  logic                      in_wen,

    X__WIntf.X_intf                   W
);

    x_w_entry_t in_entry;
    x_w_entry_t q_head;
    x_w_entry_t head;
    logic       q_enq_val;
    logic       q_val;
    logic       out_val;

    assign in_entry = x_w_make_entry(in_pc, in_seq_num, in_waddr, in_wdata, in_wen);

`ifdef X_W_RESULT_SENDER_BYPASS_EN
    logic byp_active;

    // in_rdy is low throughout reset, which keeps the bypass from
    // presenting anything on W while the block is held in reset.
    assign byp_active = in_rdy & ~q_val & in_val;
    // A result the arbiter takes in the same cycle never enters the buffer.
    assign q_enq_val  = in_val & ~(byp_active & W.rdy);
    assign head       = byp_active ? in_entry : q_head;
    assign out_val    = q_val | byp_active;
`else
    assign q_enq_val  = in_val;
    assign head       = q_head;
    assign out_val    = q_val;
`endif

    x_w_entry_queue #(
        .p_depth     (p_depth)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .enq_val_i   (q_enq_val),
        .enq_rdy_o   (in_rdy),
        .enq_entry_i (in_entry),
        .deq_val_o   (q_val),
        .deq_rdy_i   (W.rdy),
        .deq_entry_o (q_head)
    );

    // Head entry drives the writeback side; wen passes through unmodified.
    assign W.val     = out_val;
    assign W.pc      = head.pc;
    assign W.seq_num = head.seq_num;
    assign W.waddr   = head.waddr;
    assign W.wdata   = head.wdata;
    assign W.wen     = head.wen;

`ifndef SYNTHESIS
    // Line trace: fixed-width blank when idle so trace columns stay aligned.
    function automatic string line_trace(input int level);
        if (!W.val) begin
            return (level > 0) ? "                " : "  ";
        end
        if (level > 0) begin
            return $sformatf("%h:%h:%h:%h", W.seq_num, W.wen, W.waddr, W.wdata);
        end
        return $sformatf("%h", W.seq_num);
    endfunction
`endif

endmodule
`default_nettype wire

// File: tb/tb_x_w_result_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_x_w_result_sender
// Description : Directed self-checking bench for x_w_result_sender
//               (p_depth = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x_w_result_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_pc;
    logic [4:0]  in_seq_num;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata;
    logic        in_wen;

    int vectors     = 0;
    int miscompares = 0;

    int         sent;
    int         got;
    logic       acc_in;
    logic       acc_out;
    logic [4:0] obs_seq;

    X__WIntf #(.p_seq_num_bits(5)) w_if ();

    x_w_result_sender #(
        .p_depth        (2),
        .p_seq_num_bits (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_pc      (in_pc),
        .in_seq_num (in_seq_num),
        .in_waddr   (in_waddr),
        .in_wdata   (in_wdata),
        .in_wen     (in_wen),
        .W          (w_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Canonical fields for a given sequence number.
    task automatic drive(input logic [4:0] seq);
        in_seq_num = seq;
        in_pc      = 32'h100 + {27'd0, seq};
        in_waddr   = seq;
        in_wdata   = 32'h1000 + {27'd0, seq};
        in_wen     = seq[0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        in_val   = 1'b0;
        drive(5'd0);
        w_if.rdy = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_wval", {63'd0, w_if.val}, 64'd0);
            chk("rst_inrdy", {63'd0, in_rdy}, 64'd0);
        end
        rst = 1'b1;
        tick();
        chk("post_rst_inrdy", {63'd0, in_rdy}, 64'd1);
        chk("post_rst_wval", {63'd0, w_if.val}, 64'd0);

        // W.rdy while nothing is valid is ignored.
        w_if.rdy = 1'b1;
        tick();
        chk("idle_rdy_wval", {63'd0, w_if.val}, 64'd0);

`ifndef X_W_RESULT_SENDER_BYPASS_EN
        // Single transfer with W.rdy held high: visible one cycle later.
        in_val = 1'b1; in_seq_num = 5'd3; in_pc = 32'h200;
        in_waddr = 5'd5; in_wdata = 32'hDEADBEEF; in_wen = 1'b1;
        tick();
        in_val = 1'b0;
        chk("single_val", {63'd0, w_if.val}, 64'd1);
        chk("single_seq", {59'd0, w_if.seq_num}, 64'd3);
        chk("single_pc", {32'd0, w_if.pc}, 64'h200);
        chk("single_waddr", {59'd0, w_if.waddr}, 64'd5);
        chk("single_wdata", {32'd0, w_if.wdata}, 64'hDEADBEEF);
        chk("single_wen", {63'd0, w_if.wen}, 64'd1);
        tick();
        chk("single_gone", {63'd0, w_if.val}, 64'd0);
`endif

        // Backpressure: fill with 1,2, hold 3 upstream.
        w_if.rdy = 1'b0;
        in_val = 1'b1; drive(5'd1);
        tick();
        chk("bp_val1", {63'd0, w_if.val}, 64'd1);
        chk("bp_inrdy1", {63'd0, in_rdy}, 64'd1);
        drive(5'd2);
        tick();
        chk("bp_full_inrdy", {63'd0, in_rdy}, 64'd0);
        drive(5'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_inrdy", {63'd0, in_rdy}, 64'd0);
            chk("bp_hold_seq", {59'd0, w_if.seq_num}, 64'd1);
            chk("bp_hold_pc", {32'd0, w_if.pc}, 64'h101);
            chk("bp_hold_wdata", {32'd0, w_if.wdata}, 64'h1001);
        end
        w_if.rdy = 1'b1;
        tick();
        chk("bp_out2_seq", {59'd0, w_if.seq_num}, 64'd2);
        chk("bp_inrdy_back", {63'd0, in_rdy}, 64'd1);
        tick();
        in_val = 1'b0;
        chk("bp_out3_seq", {59'd0, w_if.seq_num}, 64'd3);
        chk("bp_out3_wen", {63'd0, w_if.wen}, 64'd1);
        tick();
        chk("bp_drained", {63'd0, w_if.val}, 64'd0);

        // Wrap-around stream of ten results, W.rdy toggling 1,0,1,0.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            in_val = (sent < 10);
            drive(sent[4:0]);
            w_if.rdy = (cyc % 2 == 0);
            #1;
            acc_in  = in_val & in_rdy;
            acc_out = w_if.val & w_if.rdy;
            obs_seq = w_if.seq_num;
            tick();
            if (acc_in) sent++;
            if (acc_out) begin
                chk("wrap_order", {59'd0, obs_seq}, 64'(got));
                got++;
            end
        end
        in_val = 1'b0;
        chk("wrap_count", 64'(got), 64'd10);
        chk("wrap_no_dup", {63'd0, w_if.val}, 64'd0);

        // waddr==0 with wen=1 passes through untouched.
        w_if.rdy = 1'b0;
        in_val = 1'b1; drive(5'd9); in_waddr = 5'd0; in_wen = 1'b1;
        tick();
        in_val = 1'b0;
        chk("x0_waddr", {59'd0, w_if.waddr}, 64'd0);
        chk("x0_wen", {63'd0, w_if.wen}, 64'd1);
        w_if.rdy = 1'b1;
        tick();
        w_if.rdy = 1'b0;

        // Reset mid-operation discards two buffered entries.
        in_val = 1'b1; drive(5'd20);
        tick();
        drive(5'd21);
        tick();
        in_val = 1'b0;
        chk("mid_full", {63'd0, in_rdy}, 64'd0);
        rst = 1'b0;
        tick();
        chk("mid_rst_wval", {63'd0, w_if.val}, 64'd0);
        chk("mid_rst_inrdy", {63'd0, in_rdy}, 64'd0);
        rst = 1'b1;
        w_if.rdy = 1'b1;
        tick();
        chk("mid_after_wval", {63'd0, w_if.val}, 64'd0);
        chk("mid_after_inrdy", {63'd0, in_rdy}, 64'd1);
        tick();
        chk("mid_never_seen", {63'd0, w_if.val}, 64'd0);

`ifdef X_W_RESULT_SENDER_BYPASS_EN
        // Bypass, taken in the same cycle.
        in_val = 1'b1; drive(5'd7);
        #1;
        chk("byp_same_val", {63'd0, w_if.val}, 64'd1);
        chk("byp_same_seq", {59'd0, w_if.seq_num}, 64'd7);
        tick();
        in_val = 1'b0;
        #1;
        chk("byp_consumed", {63'd0, w_if.val}, 64'd0);
        // Bypass, not taken: enqueued and presented again.
        w_if.rdy = 1'b0;
        in_val = 1'b1;
        #1;
        chk("byp_hold_val", {63'd0, w_if.val}, 64'd1);
        tick();
        in_val = 1'b0;
        #1;
        chk("byp_again_val", {63'd0, w_if.val}, 64'd1);
        chk("byp_again_seq", {59'd0, w_if.seq_num}, 64'd7);
        w_if.rdy = 1'b1;
        tick();
        chk("byp_drained", {63'd0, w_if.val}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
